// File: rtl/ifetch_pipe.sv
// ifetch_pipe: sequential instruction fetch front end with a prefetch buffer.
//
// A fetch PC register drives a synchronous instruction memory (data returns
// one cycle after the request). Returned words are queued together with their
// fetch address in a small circular buffer and presented on a valid/ready
// output port. Redirects flush everything and restart fetch at a new target.
//
// Build option: define IFETCH_PIPE_HALT_EN to enable halt-word detection.
// When it is left undefined, halted is tied low and no comparator exists.
module ifetch_pipe #(
    parameter int unsigned            ADDR_BITS  = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter int unsigned            PC_STEP    = 1,
    parameter logic [ADDR_BITS-1:0]   RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]  HALT_WORD  = '1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   enable,
    input  logic                   redirect_valid,
    input  logic [ADDR_BITS-1:0]   redirect_pc,

    output logic                   imem_en,
    output logic [ADDR_BITS-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0]  imem_rdata,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_instr,
    output logic [ADDR_BITS-1:0]   out_pc,
    output logic [ADDR_BITS-1:0]   out_next_pc,
    output logic                   halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    // One extra bit so count + inflight can never overflow the compare.
    localparam int unsigned SUM_W = PTR_W + 2;
    localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(PC_STEP);

    // Fetch side state
    logic [ADDR_BITS-1:0]  fpc_q, fpc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_BITS-1:0]  tag_q, tag_d;
    logic                  halted_q, halted_d;

    // Prefetch buffer bookkeeping
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Buffer storage is deliberately not reset; only pointers/count are.
    logic [DATA_WIDTH-1:0] buf_instr_q [DEPTH];
    logic [ADDR_BITS-1:0]  buf_pc_q    [DEPTH];

    logic [SUM_W-1:0]      occupancy;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  halt_hit;

    // Issue credit and per-cycle buffer events; redirect suppresses all of them.
    always_comb begin
        occupancy = SUM_W'(count_q) + SUM_W'(inflight_q);
        // Credit counts the in-flight word so a response always has a slot;
        // a pop this cycle does not free a slot until the next cycle.
        credit_ok = (occupancy < SUM_W'(DEPTH));
        issue     = enable & ~redirect_valid & ~halted_q & credit_ok;
        push      = inflight_q & ~redirect_valid;
        pop       = (count_q != '0) & out_ready & ~redirect_valid;
    end

`ifdef IFETCH_PIPE_HALT_EN
    // Halt is detected on the word being written into the buffer.
    always_comb begin
        halt_hit = push & (imem_rdata == HALT_WORD);
    end
`else
    // Halt detection compiled out; keep the parameter referenced harmlessly.
    logic unused_halt_word;
    always_comb begin
        halt_hit         = 1'b0;
        unused_halt_word = ^HALT_WORD;
    end
`endif

    // Next-state computation for fetch PC, in-flight tracking, pointers and halt.
    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        halted_d   = halted_q;

        if (redirect_valid) begin
            // Flush: pending response is dropped simply by not pushing it.
            fpc_d    = redirect_pc;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (issue) begin
                fpc_d      = fpc_q + STEP;
                inflight_d = 1'b1;
                tag_d      = fpc_q;
            end

            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end

            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            if (halt_hit) begin
                halted_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

    // Buffer write port: returned word and its fetch address go in at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[tail_q] <= imem_rdata;
            buf_pc_q[tail_q]    <= tag_q;
        end
    end

    // Outputs; the memory request is held off combinationally while in reset.
    always_comb begin
        imem_en     = issue & ~reset;
        imem_addr   = fpc_q;
        out_valid   = (count_q != '0);
        out_instr   = buf_instr_q[head_q];
        out_pc      = buf_pc_q[head_q];
        out_next_pc = buf_pc_q[head_q] + STEP;
        halted      = halted_q;
    end

endmodule

// File: doc/ifetch_pipe.md
IFETCH_PIPE -- requirements
Module: ifetch_pipe

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, PC and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-004 SHALL have parameter PC_STEP, default 1, PC increment per instruction.
REQ-005 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-006 SHALL have parameter HALT_WORD, default all-ones, halt encoding (REQ-031).
REQ-007 SHALL have ports: clk  in  1  the single clock, all state on rising edge; reset  in  1  asynchronous, active-high.
REQ-008 SHALL have ports: enable  in  1  fetch permitted; redirect_valid  in  1  branch/jump taken; redirect_pc  in  ADDR_BITS  target.
REQ-009 SHALL have ports: imem_en  out  1  read request; imem_addr  out  ADDR_BITS  read address; imem_rdata  in  DATA_WIDTH  word, valid the cycle after imem_en.
REQ-010 SHALL have ports: out_valid  out  1; out_ready  in  1; out_instr  out  DATA_WIDTH; out_pc  out  ADDR_BITS; out_next_pc  out  ADDR_BITS  out_pc+PC_STEP; halted  out  1.

Function
REQ-011 SHALL hold fetch PC register fpc; imem_addr SHALL equal fpc combinationally.
REQ-012 SHALL assert imem_en = enable & ~redirect_valid & ~halted & (count + inflight < DEPTH).
REQ-013 On imem_en, fpc SHALL advance by PC_STEP (modulo 2^ADDR_BITS, wrap silent); inflight<=1 with tag fpc; else inflight<=0.
REQ-014 When inflight=1 and no redirect this cycle, {tag, imem_rdata} SHALL be pushed into buffer tail.
REQ-015 out_valid SHALL be (count!=0); out_instr/out_pc SHALL present buffer head; out_next_pc = out_pc+PC_STEP truncated.
REQ-016 Pop SHALL occur on out_valid & out_ready; push and pop same cycle SHALL leave count unchanged.
REQ-017 Issue credit (REQ-012) SHALL guarantee no push to a full buffer; pops SHALL NOT grant credit in the same cycle.
REQ-018 Head/tail pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-019 redirect_valid SHALL have priority over all events: fpc<=redirect_pc, count<=0, pointers<=0, pending response discarded, halted<=0, no issue, no pop.
REQ-020 Fetch-to-out_valid latency SHALL be 2 cycles from first imem_en with empty buffer.
REQ-021 Deasserting enable SHALL stop issue only; an in-flight response SHALL still be pushed; buffer SHALL drain normally.
REQ-022 out_* SHALL remain stable while out_valid & ~out_ready.

Reset
REQ-023 On reset assertion (asynchronous): fpc=RESET_PC, count=0, pointers=0, inflight=0, halted=0.
REQ-024 During reset imem_en=0, out_valid=0, halted=0; out_instr/out_pc/out_next_pc SHALL be don't-care but deterministic (buffer contents not cleared).
REQ-025 Reset mid-operation SHALL discard all buffered and in-flight instructions; first issue SHALL be at RESET_PC on the first edge after release with enable=1.

Configuration
REQ-030 Macro IFETCH_PIPE_HALT_EN SHALL select halt detection.
REQ-031 With IFETCH_PIPE_HALT_EN defined: a pushed word equal to HALT_WORD SHALL set halted<=1 the same edge; issue SHALL stop; the halt word SHALL still be delivered; halted cleared only by redirect or reset.
REQ-032 Without IFETCH_PIPE_HALT_EN: halted SHALL be constant 0 and no comparator SHALL be synthesised.

Verification
REQ-040 Reset release, enable=1, out_ready=1, memory returns addr*16 -> out_valid first high cycle 2, out_pc 0,1,2,3 consecutively, out_instr 0x00,0x10,0x20,0x30, out_next_pc 1,2,3,4.
REQ-041 out_ready=0 from reset -> exactly DEPTH=4 imem_en pulses, then imem_en=0, out_valid=1 stable with out_pc=0; release out_ready -> pcs 0..3 in order, no loss/duplication.
REQ-042 Redirect_valid=1, redirect_pc=0x100 while buffer holds 2 entries and inflight=1 -> next cycle out_valid=0; next imem_addr=0x100; next delivered out_pc=0x100.
REQ-043 ADDR_BITS=4, RESET_PC=0xE, PC_STEP=1 -> delivered out_pc 0xE,0xF,0x0; out_next_pc for 0xF equals 0x0.
REQ-044 HALT_EN defined, word at pc=5 is HALT_WORD -> halted=1, pc 5 delivered, no imem_en after; redirect_pc=0x20 -> halted=0, fetch resumes at 0x20; macro undefined -> halted stays 0, pc 6 fetched.
REQ-045 Reset asserted mid-stream with 3 buffered entries -> out_valid=0 immediately (asynchronous); after release first out_pc=RESET_PC.
